// File: rtl/instr_load_mem.sv
// Instruction store: captures a program burst one word per cycle, then replays it in order.
// Optional macro LOAD_OVERFLOW_WRAP_EN: words past a full memory overwrite slots from 0 instead of being dropped.
module instr_load_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  LoadInstructions,
    input  logic [DATA_WIDTH-1:0] Instruction,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  load_full,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
`ifdef LOAD_OVERFLOW_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_ptr;
`endif

    // First word of a burst always lands in slot 0, whatever state we came from.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!Reset && LoadInstructions) begin
            if (state != LOAD) begin
                wr_en = 1'b1;
            end else if (count != FULL) begin
                wr_en   = 1'b1;
                wr_addr = count[ADDR_WIDTH-1:0];
            end
`ifdef LOAD_OVERFLOW_WRAP_EN
            else begin
                wr_en   = 1'b1;
                wr_addr = wrap_ptr;
            end
`endif
        end
    end

    // Memory has no reset so a loaded program survives Reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= Instruction;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else if (LoadInstructions && state != LOAD) begin
            state       <= LOAD;
            count       <= 1;
            load_full   <= 1'b0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
`ifdef LOAD_OVERFLOW_WRAP_EN
            wrap_ptr    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != 0) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                LOAD: begin
                    if (!LoadInstructions) begin
                        state <= IDLE;
                    end else if (count != FULL) begin
                        count <= count + 1'b1;
                    end else begin
                        load_full <= 1'b1;
`ifdef LOAD_OVERFLOW_WRAP_EN
                        wrap_ptr  <= wrap_ptr + 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (!fetch_stall) begin
                        instr_out   <= mem[pc];
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 1'b1;
                        if ({1'b0, pc} == count - 1'b1) state <= DONE;
                    end
                end
                DONE: begin
                    instr_valid <= 1'b0;
                    done        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_load_mem.sv
// Scoreboard bench for instr_load_mem: random bursts, random stalls, reset and abort cases.
// Build with +define+LOAD_OVERFLOW_WRAP_EN to check the wrapping overflow variant.
module tb_instr_load_mem;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          Reset;
    logic          LoadInstructions;
    logic [DW-1:0] Instruction;
    logic          fetch_stall;
    logic [DW-1:0] instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc_out;
    logic [AW:0]   count;
    logic          load_full;
    logic          done;

    instr_load_mem #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .Reset(Reset),
        .LoadInstructions(LoadInstructions),
        .Instruction(Instruction),
        .fetch_stall(fetch_stall),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc_out(pc_out),
        .count(count),
        .load_full(load_full),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ld_w [32];
    logic [31:0] mmem [DEPTH];
    int          mcount = 0;
    bit          mfull = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A word is new when valid rises, or when the previous edge was not stalled.
    initial begin
        bit pv = 0;
        bit ps = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1 && (!pv || !ps)) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got pc %0d word %h expected none",
                             pc_out, instr_out);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_pc", 64'(pc_out), 64'(e.pc));
                    check("issue_word", 64'(instr_out), 64'(e.word));
                end
            end
            pv = (instr_valid === 1'b1);
            ps = (fetch_stall === 1'b1);
        end
    end

    // Reference: slot i%DEPTH receives word i when it fits or wrapping is on.
    task automatic do_load(input int n);
        for (int i = 0; i < n; i++) begin
            LoadInstructions = 1'b1;
            Instruction      = ld_w[i];
            fetch_stall      = 1'($urandom_range(0, 1));
            tick();
            if (i == 0) begin
                exp_q.delete();
                check("load_start_count", 64'(count), 64'd1);
                check("load_start_full", 64'(load_full), 64'd0);
                check("load_start_done", 64'(done), 64'd0);
                check("load_start_valid", 64'(instr_valid), 64'd0);
            end
        end
        LoadInstructions = 1'b0;
        fetch_stall      = 1'b0;
        tick();
        mcount = (n < DEPTH) ? n : DEPTH;
        mfull  = (n > DEPTH);
        for (int i = 0; i < n; i++) begin
`ifdef LOAD_OVERFLOW_WRAP_EN
            mmem[i % DEPTH] = ld_w[i];
`else
            if (i < DEPTH) mmem[i] = ld_w[i];
`endif
        end
        check("load_count", 64'(count), 64'(mcount));
        check("load_full", 64'(load_full), 64'(mfull));
    endtask

    task automatic push_program();
        for (int i = 0; i < mcount; i++) exp_q.push_back('{pc: i, word: mmem[i]});
    endtask

    task automatic run_to_done(input bit directed);
        bit hit = 0;
        bit seen2 = 0;
        push_program();
        for (int c = 0; c < 300; c++) begin
            if (directed) begin
                fetch_stall = 1'b0;
                if (!seen2 && instr_valid && pc_out == 2) begin
                    seen2       = 1;
                    fetch_stall = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        tick();
                        check("stall_pc_hold", 64'(pc_out), 64'd2);
                        check("stall_word_hold", 64'(instr_out), 64'(mmem[2]));
                    end
                    fetch_stall = 1'b0;
                end
            end else begin
                fetch_stall = ($urandom_range(0, 2) == 0);
            end
            tick();
            if (done) begin
                hit = 1;
                break;
            end
        end
        fetch_stall = 1'b0;
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: got done %b expected 1", done);
        end
        check("done_valid", 64'(instr_valid), 64'd0);
        check("done_flag", 64'(done), 64'd1);
        check("done_count", 64'(count), 64'(mcount));
        check("done_queue_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) ld_w[i] = $urandom;
    endtask

    initial begin
        Reset            = 1'b1;
        LoadInstructions = 1'b0;
        Instruction      = '0;
        fetch_stall      = 1'b0;
        tick();
        tick();
        check("rst_instr", 64'(instr_out), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Eleven-word program, a reset cycle, then a clean replay.
        rand_words(11);
        ld_w[0] = 32'h200101A7;
        ld_w[1] = 32'h2002005C;
        Reset = 1'b0;
        do_load(11);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        run_to_done(1'b0);

        // Reload from DONE with a single word.
        ld_w[0] = 32'hDEADBEEF;
        do_load(1);
        run_to_done(1'b0);

        // Three-cycle stall while pc_out is 2.
        rand_words(11);
        do_load(11);
        run_to_done(1'b1);

        // Reset mid-run at pc_out 5, then rerun from slot 0.
        rand_words(11);
        do_load(11);
        push_program();
        for (int c = 0; c < 100; c++) begin
            if (instr_valid && pc_out == 5) break;
            tick();
        end
        check("pc5_reached", 64'(pc_out), 64'd5);
        Reset = 1'b1;
        tick();
        check("midrst_instr", 64'(instr_out), 64'd0);
        check("midrst_pc", 64'(pc_out), 64'd0);
        check("midrst_valid", 64'(instr_valid), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_count", 64'(count), 64'd11);
        exp_q.delete();
        Reset = 1'b0;
        run_to_done(1'b0);

        // Overflow and exact-fill boundaries.
        rand_words(20);
        do_load(20);
        run_to_done(1'b0);
        rand_words(DEPTH);
        do_load(DEPTH);
        run_to_done(1'b0);

        // Abort a running program with a new load.
        rand_words(10);
        do_load(10);
        push_program();
        for (int c = 0; c < 5; c++) tick();
        rand_words(7);
        do_load(7);
        run_to_done(1'b0);

        for (int t = 0; t < 12; t++) begin
            int n = $urandom_range(1, 22);
            rand_words(n);
            do_load(n);
            run_to_done(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_load_mem.md
INSTR_LOAD_MEM -- requirements
Module: instr_load_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 16, number of instruction slots; power of two, at least 2.
REQ-003 Parameter ADDR_WIDTH, default 4, equal to log2(DEPTH).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 LoadInstructions  input  1  load-mode request; one word captured per cycle while high.
REQ-007 Instruction  input  DATA_WIDTH  word to store during load.
REQ-008 fetch_stall  input  1  consumer back-pressure; holds pc and instr_out while high.
REQ-009 instr_out  output  DATA_WIDTH  fetched instruction word (registered).
REQ-010 instr_valid  output  1  instr_out holds a fresh program word.
REQ-011 pc_out  output  ADDR_WIDTH  slot index of the word in instr_out.
REQ-012 count  output  ADDR_WIDTH+1  number of words held from the last load burst.
REQ-013 load_full  output  1  sticky; a load attempt occurred with count equal to DEPTH.
REQ-014 done  output  1  last loaded word has been issued.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-016 In IDLE, DONE or RUN, LoadInstructions=1 SHALL clear count and load_full, write Instruction to slot 0, set count=1, and go to LOAD; an active RUN is aborted.
REQ-017 In LOAD with LoadInstructions=1 and count<DEPTH, the block SHALL write Instruction to slot count and increment count.
REQ-018 In LOAD with LoadInstructions=1 and count==DEPTH, the block SHALL set load_full; handling of the word is given by REQ-029 and REQ-030.
REQ-019 In LOAD with LoadInstructions=0, the block SHALL go to IDLE with no write.
REQ-020 In IDLE with LoadInstructions=0 and count!=0, the block SHALL go to RUN with internal pc=0; with count==0 it stays in IDLE.
REQ-021 In RUN with fetch_stall=0, the block SHALL, each cycle, register instr_out=mem[pc] and pc_out=pc, set instr_valid=1, and increment pc; read latency is 1 cycle.
REQ-022 In RUN with fetch_stall=1, instr_out, pc_out, instr_valid and pc SHALL hold.
REQ-023 The cycle that issues slot count-1 SHALL be followed by DONE, where instr_valid=0 and done=1; instr_out and pc_out hold their last values.
REQ-024 DONE SHALL persist until Reset or LoadInstructions=1.
REQ-025 When LoadInstructions and fetch_stall are both high, the load SHALL take precedence.

Reset
REQ-026 Reset=1 SHALL, at the next edge and with priority over all inputs, force state=IDLE, pc=0, instr_out=0, pc_out=0, instr_valid=0, and done=0.
REQ-027 Reset SHALL NOT clear memory contents, count or load_full, so a loaded program reruns after Reset.
REQ-028 Reset asserted mid-LOAD or mid-RUN SHALL drop that cycle's write or fetch.

Configuration
REQ-029 With macro LOAD_OVERFLOW_WRAP_EN defined, a load word arriving at count==DEPTH SHALL overwrite slot (writes-after-full mod DEPTH), starting at slot 0; count stays at DEPTH.
REQ-030 Without LOAD_OVERFLOW_WRAP_EN, a load word arriving at count==DEPTH SHALL be discarded, and memory and count stay unchanged.

Verification
REQ-031 Defaults: load 11 words 0x200101A7, 0x2002005C, ... (one per cycle), then LoadInstructions=0 and one Reset cycle -> RUN issues slots 0..10 in order on consecutive cycles, first instr_out=0x200101A7 with pc_out=0, then done=1 and count=11.
REQ-032 DEPTH=4, no macro: load 6 words A0..A5 -> count=4, load_full=1, run issues A0..A3; with LOAD_OVERFLOW_WRAP_EN the run issues A4,A5,A2,A3.
REQ-033 RUN with fetch_stall high for 3 cycles at pc_out=2 -> instr_out and pc_out hold for 3 cycles, then pc_out=3 follows; no word is skipped or repeated.
REQ-034 Reset pulsed while pc_out=5 of an 11-word program -> all outputs are 0 the next cycle, count stays 11, and the rerun starts at pc_out=0.
REQ-035 LoadInstructions raised in DONE with word 0xDEADBEEF -> done=0, count=1, load_full=0; the next run issues only 0xDEADBEEF, then done=1.
